// File: rtl/victim_refill_ctrl.sv
// I-cache miss sequencer: looks up the victim buffer, falls back to a 16-beat memory burst,
// returns the refill line, then pushes the evicted I-cache line into the victim buffer.
module victim_refill_ctrl #(
  parameter int TAG_WIDTH   = 20,
  parameter int INDEX_WIDTH = 6,
  parameter int BEATS       = 16,
  localparam int LA         = TAG_WIDTH + INDEX_WIDTH,
  localparam int LINE_W     = 32 * BEATS,
  localparam int CW         = $clog2(BEATS),
  localparam int OFF        = $clog2(BEATS * 4)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              miss_req,
  input  logic [LA-1:0]     miss_addr,
  input  logic              evict_valid,
  input  logic [LA-1:0]     evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  output logic              busy,
  output logic [LA-1:0]     vc_rtag,
  input  logic              vc_hit,
  input  logic [LINE_W-1:0] vc_rdata,
  output logic              vc_we,
  output logic [LA-1:0]     vc_wtag,
  output logic [LINE_W-1:0] vc_wdata,
  output logic              mem_rd_req,
  output logic [31:0]       mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              refill_valid,
  output logic [LINE_W-1:0] refill_data,
  output logic              refill_from_victim
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_DATA, S_REFILL, S_VC_WR, S_VC_GAP
  } state_t;

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic [CW-1:0]       beat_q;
  logic [LA-1:0]       miss_addr_q;
  logic                evict_valid_q;
  logic [LA-1:0]       evict_addr_q;
  logic [LINE_W-1:0]   evict_data_q;
  logic [LINE_W-1:0]   line_q;
  logic                from_victim_q;
  logic [LA+OFF-1:0]   byte_addr;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    unique case (state_q)
      S_IDLE:     if (miss_req) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = vc_hit ? S_REFILL : S_MEM_REQ;
      S_MEM_REQ:  if (mem_rd_gnt) state_d = S_MEM_DATA;
      S_MEM_DATA: if (mem_rd_valid && beat_q == CW'(BEATS - 1)) state_d = S_REFILL;
      S_REFILL:   state_d = evict_valid_q ? S_VC_WR : S_IDLE;
      S_VC_WR: begin
        // Two-cycle states use phase_q as a one-bit cycle counter.
        phase_d = ~phase_q;
        if (phase_q) state_d = S_VC_GAP;
      end
      S_VC_GAP: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      beat_q        <= '0;
      miss_addr_q   <= '0;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      evict_data_q  <= '0;
      // NOTE: the line buffer is cleared on reset so a discarded partial line never leaks out.
      line_q        <= '0;
      from_victim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (state_q == S_IDLE && miss_req) begin
        miss_addr_q   <= miss_addr;
        evict_valid_q <= evict_valid;
        evict_addr_q  <= evict_addr;
        evict_data_q  <= evict_data;
      end
      if (state_q == S_LOOKUP) begin
        from_victim_q <= vc_hit;
        if (vc_hit) line_q <= vc_rdata;
      end
      if (state_q == S_MEM_DATA && mem_rd_valid) begin
        line_q[32*beat_q +: 32] <= mem_rd_data;
        beat_q <= (beat_q == CW'(BEATS - 1)) ? '0 : beat_q + 1'b1;
      end
    end
  end

  // Request/write strobes are gated by rstn so they drop in the same cycle reset asserts.
  assign busy               = (state_q != S_IDLE);
  assign mem_rd_req         = rstn && (state_q == S_MEM_REQ);
  assign vc_we              = rstn && (state_q == S_VC_WR);
  assign refill_valid       = (state_q == S_REFILL);
  assign refill_from_victim = refill_valid && from_victim_q;
  assign refill_data        = line_q;
  assign vc_rtag            = miss_addr_q;
  assign vc_wtag            = evict_addr_q;
  assign vc_wdata           = evict_data_q;
  assign byte_addr          = {miss_addr_q, {OFF{1'b0}}};
  assign mem_rd_addr        = 32'(byte_addr);

endmodule
